// File: rtl/rr_encoder8_3_if.sv
// Request/grant bundle for rr_encoder8_3: sticky request lines in, encoded grant plus handshake out.
// The master side is the encoder; the slave side is the requester/consumer.
interface rr_encoder8_3_if;
  logic [7:0] req;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic [7:0] onehot;
  logic [7:0] pending;

  modport master (
    input  req,
    input  ready,
    output y,
    output valid,
    output onehot,
    output pending
  );

  modport slave (
    output req,
    output ready,
    input  y,
    input  valid,
    input  onehot,
    input  pending
  );
endinterface

// File: rtl/rr_encoder8_3.sv
// Sticky 8-to-3 request encoder: round-robin (RR=1) or fixed-priority grant, held under valid/ready.
// Request-to-valid latency is 2 edges; each accepted grant is followed by one idle cycle.
module rr_encoder8_3 #(
  parameter bit RR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  rr_encoder8_3_if.master bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] onehot_q, onehot_d;
  logic [2:0] y_q, y_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] clr;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] k;
  logic       found;
  logic       accept;

  assign accept = (state_q == HOLD) && bus.ready;
  assign clr    = accept ? onehot_q : 8'h00;

  // A request arriving on the accept edge survives the clear and is granted again later.
  assign pending_d = (pending_q & ~clr) | bus.req;

  assign base = RR ? ptr_q : 3'd0;

  // Ascending wrap-around search of the registered pending set; same-cycle req is not seen.
  always_comb begin
    found = 1'b0;
    k     = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        k     = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          y_d      = k;
          onehot_d = 8'h01 << k;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.ready) begin
          ptr_d    = y_q + 3'd1;
          onehot_d = 8'h00;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      onehot_q  <= 8'h00;
      y_q       <= 3'd0;
      ptr_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.valid   = (state_q == HOLD);
  assign bus.onehot  = onehot_q;
  assign bus.pending = pending_q;

  a_onehot_tracks_y: assert property (@(posedge clk) disable iff (reset)
    (state_q == HOLD) ? (onehot_q == (8'h01 << y_q)) : (onehot_q == 8'h00));

endmodule

// File: tb/tb_rr_encoder8_3.sv
// Bench for rr_encoder8_3: round-robin and fixed-priority instances driven in lockstep.
module tb_rr_encoder8_3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_s;
  logic       ready_s;

  always #5 clk = ~clk;

  rr_encoder8_3_if bus1 ();
  rr_encoder8_3_if bus0 ();

  assign bus1.req   = req_s;
  assign bus1.ready = ready_s;
  assign bus0.req   = req_s;
  assign bus0.ready = ready_s;

  rr_encoder8_3 #(.RR(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));
  rr_encoder8_3 #(.RR(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));

  int total  = 0;
  int passed = 0;

  // Reference state: index 0 models the fixed-priority instance, index 1 the round-robin one.
  logic [7:0] m_pend [2];
  int         m_ptr  [2];
  bit         m_val  [2];
  int         m_y    [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input logic [7:0] rq, input bit rdy);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] np;
      int         start;
      bit         got;
      if (rst) begin
        m_pend[m] = 8'h00; m_ptr[m] = 0; m_val[m] = 1'b0; m_y[m] = 0;
      end else begin
        np = m_pend[m];
        if (m_val[m]) begin
          if (rdy) begin
            np[m_y[m]] = 1'b0;
            m_ptr[m]   = (m_y[m] + 1) % 8;
            m_val[m]   = 1'b0;
          end
        end else if (m_pend[m] != 8'h00) begin
          start = (m == 1) ? m_ptr[m] : 0;
          got   = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (!got && m_pend[m][(start + i) % 8]) begin
              got      = 1'b1;
              m_y[m]   = (start + i) % 8;
              m_val[m] = 1'b1;
            end
          end
        end
        m_pend[m] = np | rq;
      end
    end
  endtask

  function automatic int exp_onehot(input int m);
    return m_val[m] ? (1 << m_y[m]) : 0;
  endfunction

  task automatic compare_all();
    chk("rr.valid",   int'(bus1.valid),   int'(m_val[1]));
    chk("rr.y",       int'(bus1.y),       m_y[1]);
    chk("rr.onehot",  int'(bus1.onehot),  exp_onehot(1));
    chk("rr.pending", int'(bus1.pending), int'(m_pend[1]));
    chk("rr.ptr",     int'(dut1.ptr_q),   m_ptr[1]);
    chk("fp.valid",   int'(bus0.valid),   int'(m_val[0]));
    chk("fp.y",       int'(bus0.y),       m_y[0]);
    chk("fp.onehot",  int'(bus0.onehot),  exp_onehot(0));
    chk("fp.pending", int'(bus0.pending), int'(m_pend[0]));
  endtask

  task automatic cyc(input bit rst, input logic [7:0] rq, input bit rdy);
    reset   = rst;
    req_s   = rq;
    ready_s = rdy;
    @(posedge clk);
    model_edge(rst, rq, rdy);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         rdy;
    bit         v;
    int         y;
    logic [7:0] pend;
    int         ptr;
  } vec_t;

  vec_t tbl [27];
  int   q1 [$];
  int   q0 [$];

  initial begin
    reset = 1'b1; req_s = 8'h00; ready_s = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 8'h00; m_ptr[m] = 0; m_val[m] = 1'b0; m_y[m] = 0;
    end

    // Reset/idle, single request, then a round-robin sweep of all eight lines.
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00, 0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0};
    tbl[4]  = '{1'b0, 8'h20, 1'b1, 1'b0, 0, 8'h20, 0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5, 8'h20, 0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 8'h00, 6};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 8'h00, 6};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0};
    tbl[9]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 0, 8'hFF, 0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'hFF, 0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hFE, 1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 8'hFE, 1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hFC, 2};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 8'hFC, 2};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hF8, 3};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 8'hF8, 3};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'hF0, 4};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 4, 8'hF0, 4};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 8'hE0, 5};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 5, 8'hE0, 5};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 8'hC0, 6};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 6, 8'hC0, 6};
    tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 6, 8'h80, 7};
    tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 7, 8'h80, 7};
    tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 7, 8'h00, 0};
    tbl[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 7, 8'h00, 0};

    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      chk($sformatf("tbl[%0d].valid", i),   int'(bus1.valid),   int'(tbl[i].v));
      chk($sformatf("tbl[%0d].y", i),       int'(bus1.y),       tbl[i].y);
      chk($sformatf("tbl[%0d].onehot", i),  int'(bus1.onehot),  tbl[i].v ? (1 << tbl[i].y) : 0);
      chk($sformatf("tbl[%0d].pending", i), int'(bus1.pending), int'(tbl[i].pend));
      chk($sformatf("tbl[%0d].ptr", i),     int'(dut1.ptr_q),   tbl[i].ptr);
    end

    // Wrap: leave ptr at 7 with pending 1000_1001, then record grant order.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h40, 1'b1);
    cyc(1'b0, 8'h89, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrap.ptr",     int'(dut1.ptr_q),   7);
    chk("wrap.pending", int'(bus1.pending), 8'h89);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (bus1.valid) q1.push_back(int'(bus1.y));
      if (bus0.valid) q0.push_back(int'(bus0.y));
    end
    chk("wrap.rr.count", q1.size(), 3);
    chk("wrap.fp.count", q0.size(), 3);
    if (q1.size() == 3) begin
      chk("wrap.rr.g0", q1[0], 7); chk("wrap.rr.g1", q1[1], 0); chk("wrap.rr.g2", q1[2], 3);
    end
    if (q0.size() == 3) begin
      chk("wrap.fp.g0", q0[0], 0); chk("wrap.fp.g1", q0[1], 3); chk("wrap.fp.g2", q0[2], 7);
    end

    // Backpressure: grant 4 held for 5 cycles while bit 0 is pulsed.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h10, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
      chk("bp.valid",  int'(bus1.valid),  1);
      chk("bp.y",      int'(bus1.y),      4);
      chk("bp.onehot", int'(bus1.onehot), 8'h10);
    end
    chk("bp.pending", int'(bus1.pending), 8'h11);
    cyc(1'b0, 8'h00, 1'b1);
    chk("bp.acc.valid",   int'(bus1.valid),   0);
    chk("bp.acc.pending", int'(bus1.pending), 8'h01);
    cyc(1'b0, 8'h00, 1'b1);
    chk("bp.next.valid", int'(bus1.valid), 1);
    chk("bp.next.y",     int'(bus1.y),     0);

    // Set/clear collision on the accept edge, then reset while holding a grant.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h04, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("col.grant.y", int'(bus1.y), 2);
    cyc(1'b0, 8'h04, 1'b1);
    chk("col.acc.valid",   int'(bus1.valid),   0);
    chk("col.acc.pending", int'(bus1.pending), 8'h04);
    chk("col.acc.ptr",     int'(dut1.ptr_q),   3);
    cyc(1'b0, 8'h00, 1'b0);
    chk("col.regrant.valid", int'(bus1.valid), 1);
    chk("col.regrant.y",     int'(bus1.y),     2);
    cyc(1'b1, 8'hFF, 1'b1);
    chk("rst.valid",   int'(bus1.valid),   0);
    chk("rst.pending", int'(bus1.pending), 0);
    chk("rst.onehot",  int'(bus1.onehot),  0);
    chk("rst.ptr",     int'(dut1.ptr_q),   0);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] rq;
      rq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cyc($urandom_range(0, 79) == 0, rq, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
